// File: rtl/id_ex_skid_reg_if.sv
// Valid/ready stream carrying one ID/EX entry (control bundle plus data bundle).
interface id_ex_skid_reg_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 143
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with optional skid entry (enable with macro ID_EX_SKID_EN),
// synchronous flush and a saturating downstream-starvation counter.
module id_ex_skid_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 143,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_ex_skid_reg_if.slave  s,
  id_ex_skid_reg_if.master m,
  output logic [1:0]       occupancy,
  input  logic             bubble_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              m_valid_q, m_valid_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              s_ready;
  logic              s_fire;
  logic              m_fire;

`ifdef ID_EX_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              s_ready_q, s_ready_d;

  // Registered ready: upstream never sees a combinational path from m_ready.
  assign s_ready = s_ready_q;
`else
  assign s_ready = ~m_valid_q | m.ready;
`endif

  assign s_fire    = s.valid & s_ready;
  assign m_fire    = m_valid_q & m.ready;
  assign s.ready   = s_ready;
  assign m.valid   = m_valid_q;
  assign m.ctrl    = main_ctrl_q;
  assign m.data    = main_data_q;
  assign occupancy = state_q;
  assign bubble_cnt = bubble_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
`ifdef ID_EX_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
`endif
    if (flush) begin
      // Squash drops control only; data bundles keep their last value.
      state_d     = EMPTY;
      main_ctrl_d = '0;
`ifdef ID_EX_SKID_EN
      skid_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (s_fire) begin
            state_d     = ONE;
            main_ctrl_d = s.ctrl;
            main_data_d = s.data;
          end
        end
        ONE: begin
          if (s_fire && m_fire) begin
            main_ctrl_d = s.ctrl;
            main_data_d = s.data;
          end else if (m_fire) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
`ifdef ID_EX_SKID_EN
          else if (s_fire) begin
            state_d     = FULL;
            skid_ctrl_d = s.ctrl;
            skid_data_d = s.data;
          end
`endif
        end
`ifdef ID_EX_SKID_EN
        FULL: begin
          if (m_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
    m_valid_d = (state_d != EMPTY);
`ifdef ID_EX_SKID_EN
    s_ready_d = (state_d != FULL);
`endif
  end

  always_comb begin
    bubble_d = bubble_q;
    if (bubble_clr) begin
      bubble_d = '0;
    end else if (m.ready && !m_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      m_valid_q   <= 1'b0;
      bubble_q    <= '0;
`ifdef ID_EX_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      s_ready_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      m_valid_q   <= m_valid_d;
      bubble_q    <= bubble_d;
`ifdef ID_EX_SKID_EN
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      s_ready_q   <= s_ready_d;
`endif
    end
  end

endmodule
